// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : shared types and helpers for the FFT address generator
// Rev 1.0 : initial release
// ============================================================================
package fft_pkg;

    localparam int DEF_N_POINTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READOUT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RD_A    = 3'd3,
        ST_RD_B    = 3'd4,
        ST_WAIT_WB = 3'd5,
        ST_WR_A    = 3'd6,
        ST_WR_B    = 3'd7
    } addr_gen_state_t;

    // Reverses the low 'width' bits of value; callers cast the result to their width.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] rev;
        rev = '0;
        for (int i = 0; i < width; i++) begin
            rev[i] = value[width-1-i];
        end
        return rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen_if.sv
`default_nettype none
// ============================================================================
// fft_addr_gen_if : control-FSM <-> address generator bundle
// Rev 1.0 : initial release
// ============================================================================
interface fft_addr_gen_if #(
    parameter int N_POINTS = 16
);
    localparam int ADDR_W = $clog2(N_POINTS);
    localparam int STG_W  = $clog2(ADDR_W);

    logic              start_i;
    logic              en_cnt_samples_i;
    logic              wr_mem_i;
    logic              en_cnt_rd_i;
    logic              read_ram_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic              wr_sel_o;
    logic [ADDR_W-2:0] tw_addr_o;
    logic [STG_W-1:0]  stage_o;
    logic              end_samples_o;
    logic              end_read_1_o;
    logic              end_read_2_o;
    logic              end_write_1_o;
    logic              end_algo_o;

    modport master (
        output start_i, en_cnt_samples_i, wr_mem_i, en_cnt_rd_i, read_ram_i,
        input  mem_addr_o, mem_we_o, wr_sel_o, tw_addr_o, stage_o,
        input  end_samples_o, end_read_1_o, end_read_2_o, end_write_1_o, end_algo_o
    );

    modport slave (
        input  start_i, en_cnt_samples_i, wr_mem_i, en_cnt_rd_i, read_ram_i,
        output mem_addr_o, mem_we_o, wr_sel_o, tw_addr_o, stage_o,
        output end_samples_o, end_read_1_o, end_read_2_o, end_write_1_o, end_algo_o
    );
endinterface
`default_nettype wire

// File: rtl/fft_bfly_idx.sv
`default_nettype none
// ============================================================================
// fft_bfly_idx : radix-2 DIT butterfly operand and twiddle index (combinational)
// Rev 1.0 : initial release
// ============================================================================
module fft_bfly_idx #(
    parameter int ADDR_W = 4,
    parameter int STG_W  = 2
) (
    input  logic [STG_W-1:0]  stage,
    input  logic [ADDR_W-2:0] bfly,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-2:0] tw
);
    logic [ADDR_W-1:0] j_ext;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;

    // Operand A is j with a zero bit inserted at position 'stage'.
    always_comb begin
        j_ext  = {1'b0, bfly};
        half   = ADDR_W'(1) << stage;
        pos    = j_ext & (half - 1'b1);
        addr_a = ((j_ext >> stage) << (int'(stage) + 1)) | pos;
        addr_b = addr_a + half;
        tw     = (ADDR_W-1)'(pos << (ADDR_W - 1 - int'(stage)));
    end
endmodule
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// fft_addr_gen : FFT sample/result RAM address and sequence generator
// Build option FFT_ADDR_BITREV_EN: bit-reverse on LOAD instead of READOUT.
// Rev 1.0 : initial release
// ============================================================================
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fft_addr_gen_if.slave bus
);
    localparam int ADDR_W = $clog2(N_POINTS);
    localparam int STG_W  = $clog2(ADDR_W);
    localparam int J_W    = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] N_LAST = '1;
    localparam logic [J_W-1:0]    J_LAST = '1;
    localparam logic [STG_W-1:0]  S_LAST = STG_W'(ADDR_W - 1);

    addr_gen_state_t   state, state_nxt;
    logic [ADDR_W-1:0] n, n_nxt;
    logic [J_W-1:0]    j, j_nxt;
    logic [STG_W-1:0]  s, s_nxt;

    logic [ADDR_W-1:0] addr_nxt;
    logic              we_nxt, sel_nxt;
    logic [J_W-1:0]    tw_nxt;
    logic [STG_W-1:0]  stage_nxt;
    logic              es_nxt, er1_nxt, er2_nxt, ew1_nxt, algo_nxt;

    logic [ADDR_W-1:0] a_addr, b_addr, n_rev, ld_addr, rd_addr;
    logic [J_W-1:0]    tw_idx;
    logic              last_bfly;

    fft_bfly_idx #(
        .ADDR_W (ADDR_W),
        .STG_W  (STG_W)
    ) u_bfly_idx (
        .stage  (s),
        .bfly   (j),
        .addr_a (a_addr),
        .addr_b (b_addr),
        .tw     (tw_idx)
    );

    assign n_rev     = ADDR_W'(bitrev(32'(n), ADDR_W));
    assign last_bfly = (s == S_LAST) && (j == J_LAST);

`ifdef FFT_ADDR_BITREV_EN
    assign ld_addr = n_rev;
    assign rd_addr = n;
`else
    assign ld_addr = n;
    assign rd_addr = n_rev;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            n     <= '0;
            j     <= '0;
            s     <= '0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            j     <= j_nxt;
            s     <= s_nxt;
        end
    end

    // Outputs are computed from the current state and registered, so they
    // trail the state register by one cycle.
    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        j_nxt     = j;
        s_nxt     = s;
        addr_nxt  = '0;
        we_nxt    = 1'b0;
        sel_nxt   = 1'b0;
        tw_nxt    = '0;
        stage_nxt = s;
        es_nxt    = 1'b0;
        er1_nxt   = 1'b0;
        er2_nxt   = 1'b0;
        ew1_nxt   = 1'b0;
        algo_nxt  = 1'b0;

        if (bus.start_i) begin
            state_nxt = ST_LOAD;
            n_nxt     = '0;
            j_nxt     = '0;
            s_nxt     = '0;
            stage_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.read_ram_i) state_nxt = ST_READOUT;
                end
                ST_READOUT: begin
                    if (bus.read_ram_i) begin
                        addr_nxt = rd_addr;
                        n_nxt    = n + 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        n_nxt     = '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.en_cnt_samples_i && bus.wr_mem_i) begin
                        we_nxt   = 1'b1;
                        addr_nxt = ld_addr;
                        n_nxt    = n + 1'b1;
                        if (n == N_LAST) begin
                            es_nxt    = 1'b1;
                            state_nxt = ST_RD_A;
                        end
                    end
                end
                ST_RD_A: begin
                    addr_nxt  = a_addr;
                    er1_nxt   = 1'b1;
                    tw_nxt    = tw_idx;
                    algo_nxt  = last_bfly;
                    state_nxt = ST_RD_B;
                end
                ST_RD_B: begin
                    addr_nxt  = b_addr;
                    er2_nxt   = 1'b1;
                    tw_nxt    = tw_idx;
                    algo_nxt  = last_bfly;
                    state_nxt = ST_WAIT_WB;
                end
                ST_WAIT_WB: begin
                    tw_nxt   = tw_idx;
                    algo_nxt = last_bfly;
                    if (bus.wr_mem_i && bus.en_cnt_rd_i) state_nxt = ST_WR_A;
                end
                ST_WR_A: begin
                    addr_nxt  = a_addr;
                    we_nxt    = 1'b1;
                    ew1_nxt   = 1'b1;
                    tw_nxt    = tw_idx;
                    algo_nxt  = last_bfly;
                    state_nxt = ST_WR_B;
                end
                ST_WR_B: begin
                    addr_nxt = b_addr;
                    we_nxt   = 1'b1;
                    sel_nxt  = 1'b1;
                    tw_nxt   = tw_idx;
                    algo_nxt = last_bfly;
                    j_nxt    = j + 1'b1;
                    if (last_bfly) begin
                        s_nxt     = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        if (j == J_LAST) s_nxt = s + 1'b1;
                        state_nxt = ST_RD_A;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.mem_addr_o    <= '0;
            bus.mem_we_o      <= 1'b0;
            bus.wr_sel_o      <= 1'b0;
            bus.tw_addr_o     <= '0;
            bus.stage_o       <= '0;
            bus.end_samples_o <= 1'b0;
            bus.end_read_1_o  <= 1'b0;
            bus.end_read_2_o  <= 1'b0;
            bus.end_write_1_o <= 1'b0;
            bus.end_algo_o    <= 1'b0;
        end else begin
            bus.mem_addr_o    <= addr_nxt;
            bus.mem_we_o      <= we_nxt;
            bus.wr_sel_o      <= sel_nxt;
            bus.tw_addr_o     <= tw_nxt;
            bus.stage_o       <= stage_nxt;
            bus.end_samples_o <= es_nxt;
            bus.end_read_1_o  <= er1_nxt;
            bus.end_read_2_o  <= er2_nxt;
            bus.end_write_1_o <= ew1_nxt;
            bus.end_algo_o    <= algo_nxt;
        end
    end
endmodule
`default_nettype wire
